ej32_trace_buf: RTL and testbench

Synthesizable on-chip execution trace recorder for eJ32. It samples per-cycle core state (p, a, opcode, phase, rp, tos) into a circular RAM buffer, with mode filtering and a PC trigger. Captured records are frozen and read out oldest-first over a valid/ready port. Readout can feed a debug UART, or the bench can drain it instead of printing trace lines.

---
 rtl/ej32_pkg.sv | 35 +++
 rtl/ej32_trace_ram.sv | 32 +++
 rtl/ej32_trace_buf.sv | 163 ++++++++++++++++
 tb/tb_ej32_trace_buf.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ej32_pkg.sv
// Shared types and constants for the eJ32 execution trace recorder.
package ej32_pkg;

  localparam int unsigned IU_SZ_D = 16;
  localparam int unsigned DW_D    = 32;
  localparam int unsigned RP_SZ_D = 8;

  localparam logic [7:0] OP_CALL = 8'hB6;
  localparam logic [7:0] OP_RET  = 8'hB1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  typedef enum logic [1:0] {
    MODE_ALL   = 2'd0,
    MODE_CALL  = 2'd1,
    MODE_RANGE = 2'd2,
    MODE_RSVD  = 2'd3
  } trace_mode_t;

  // Layout of one trace record as presented on rd_data (default widths).
  typedef struct packed {
    logic [7:0]         op;
    logic [2:0]         ph;
    logic [RP_SZ_D-1:0] rp;
    logic [IU_SZ_D-1:0] p;
    logic [IU_SZ_D-1:0] a;
    logic [DW_D-1:0]    t;
  } trace_rec_t;

endpackage

// File: rtl/ej32_trace_ram.sv
// Simple dual-port record store: one write port, one registered read port.
module ej32_trace_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned W     = 83,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register holds its value between reads so the consumer sees stable data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ej32_trace_buf.sv
// eJ32 execution trace recorder: filtered circular capture with PC trigger
// and oldest-first valid/ready readout.
module ej32_trace_buf
  import ej32_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IU_SZ = IU_SZ_D,
  parameter int unsigned DW    = DW_D,
  parameter int unsigned RP_SZ = RP_SZ_D,
  parameter int unsigned POST  = 16,
  localparam int unsigned REC_W = 8 + 3 + RP_SZ + 2*IU_SZ + DW,
  localparam int unsigned CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [IU_SZ-1:0] lo,
  input  logic [IU_SZ-1:0] hi,
  input  logic             trig_en,
  input  logic [IU_SZ-1:0] trig_pc,
  input  logic             arm,
  input  logic             stop,
  input  logic             tr_vld,
  input  logic [IU_SZ-1:0] tr_p,
  input  logic [IU_SZ-1:0] tr_a,
  input  logic [7:0]       tr_op,
  input  logic [2:0]       tr_ph,
  input  logic [RP_SZ-1:0] tr_rp,
  input  logic [DW-1:0]    tr_t,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [REC_W-1:0] rd_data,
  output logic [1:0]       state_o,
  output logic [CW-1:0]    cnt,
  output logic             wrapped
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_state_t     r_state;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rdp;
  logic [AW-1:0]    r_post;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_rem;
  logic             r_wrapped;
  logic             r_rd_vld;

  logic             w_q;
  logic             w_hit;
  logic             w_we;
  logic             w_fetch;
  logic             w_done_n;
  logic [AW-1:0]    w_wp_n;
  logic [CW-1:0]    w_cnt_n;
  logic             w_wrap_n;
  logic [REC_W-1:0] w_wrec;

  // Sample qualification by capture mode; reserved mode behaves as ALL.
  always_comb begin
    w_q = 1'b0;
    case (trace_mode_t'(mode))
      MODE_CALL:  w_q = ((tr_op == OP_CALL) && (tr_ph == 3'd2)) ||
                        ((tr_op == OP_RET)  && (tr_ph == 3'd0));
      MODE_RANGE: w_q = (tr_p >= lo) && (tr_p <= hi);
      default:    w_q = 1'b1;
    endcase
    w_q = w_q && tr_vld;
  end

  assign w_hit  = trig_en && w_q && (tr_p == trig_pc);
  assign w_we   = !arm && w_q && ((r_state == ST_ARMED) || (r_state == ST_POST));
  assign w_wrec = {tr_op, tr_ph, tr_rp, tr_p, tr_a, tr_t};

  // Post-write pointer/count values; DONE entry snapshots these, not the old ones.
  assign w_wp_n   = w_we ? r_wp + AW'(1) : r_wp;
  assign w_cnt_n  = (w_we && (r_cnt != CW'(DEPTH))) ? r_cnt + CW'(1) : r_cnt;
  assign w_wrap_n = r_wrapped || (w_we && (r_cnt == CW'(DEPTH)));

  always_comb begin
    w_done_n = 1'b0;
    if (!arm) begin
      if (r_state == ST_ARMED)     w_done_n = stop || (w_hit && (POST == 0));
      else if (r_state == ST_POST) w_done_n = stop || (w_q && (r_post == AW'(1)));
    end
  end

  // Prefetch: issue a RAM read whenever the output slot is empty or being consumed.
  assign w_fetch = (r_state == ST_DONE) && (r_rem != '0) && (!r_rd_vld || rd_rdy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_wp      <= '0;
      r_rdp     <= '0;
      r_post    <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_wrapped <= 1'b0;
      r_rd_vld  <= 1'b0;
    end else if (arm) begin
      r_state   <= ST_ARMED;
      r_wp      <= '0;
      r_post    <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_wrapped <= 1'b0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_wp      <= w_wp_n;
      r_cnt     <= w_cnt_n;
      r_wrapped <= w_wrap_n;
      case (r_state)
        ST_ARMED: begin
          if (w_done_n) begin
            r_state <= ST_DONE;
          end else if (w_hit) begin
            r_post  <= AW'(POST);
            r_state <= ST_POST;
          end
        end
        ST_POST: begin
          if (w_q)      r_post  <= r_post - AW'(1);
          if (w_done_n) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (w_fetch) begin
            r_rdp    <= r_rdp + AW'(1);
            r_rem    <= r_rem - CW'(1);
            r_rd_vld <= 1'b1;
          end else if (rd_rdy) begin
            r_rd_vld <= 1'b0;
          end
        end
        default: ;
      endcase
      if (w_done_n) begin
        r_rdp <= w_wrap_n ? w_wp_n : '0;
        r_rem <= w_cnt_n;
      end
    end
  end

  ej32_trace_ram #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_wp),
    .i_wdata (w_wrec),
    .i_re    (w_fetch),
    .i_raddr (r_rdp),
    .o_rdata (rd_data)
  );

  assign rd_vld  = r_rd_vld;
  assign state_o = r_state;
  assign cnt     = r_cnt;
  assign wrapped = r_wrapped;

endmodule

// File: tb/tb_ej32_trace_buf.sv
// Directed bench for ej32_trace_buf with DEPTH=8, POST=3.
module tb_ej32_trace_buf;
  import ej32_pkg::*;

  localparam int unsigned REC_W = 83;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [15:0]      lo = '0, hi = '0, trig_pc = '0;
  logic             trig_en = 1'b0, arm = 1'b0, stop = 1'b0;
  logic             tr_vld = 1'b0;
  logic [15:0]      tr_p = '0, tr_a = '0;
  logic [7:0]       tr_op = '0;
  logic [2:0]       tr_ph = '0;
  logic [7:0]       tr_rp = '0;
  logic [31:0]      tr_t = '0;
  logic             rd_vld;
  logic             rd_rdy = 1'b0;
  logic [REC_W-1:0] rd_data;
  logic [1:0]       state_o;
  logic [3:0]       cnt;
  logic             wrapped;

  int n_tot = 0;
  int n_bad = 0;
  trace_rec_t got [$];

  ej32_trace_buf #(.DEPTH(8), .POST(3)) dut (
    .clk(clk), .rst(rst), .mode(mode), .lo(lo), .hi(hi),
    .trig_en(trig_en), .trig_pc(trig_pc), .arm(arm), .stop(stop),
    .tr_vld(tr_vld), .tr_p(tr_p), .tr_a(tr_a), .tr_op(tr_op), .tr_ph(tr_ph),
    .tr_rp(tr_rp), .tr_t(tr_t), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
    .rd_data(rd_data), .state_o(state_o), .cnt(cnt), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic smp(input logic [15:0] p, input logic [7:0] op = 8'h00,
                     input logic [2:0] ph = 3'd0, input logic [7:0] rp = 8'h00);
    tr_vld = 1'b1; tr_p = p; tr_a = ~p; tr_op = op; tr_ph = ph; tr_rp = rp;
    tr_t = {16'hA5A5, p};
    tick();
    tr_vld = 1'b0;
  endtask

  // Consume records for ncyc cycles; checks output stability during stalls.
  task automatic drain(input int ncyc, input bit rnd);
    logic             stalled;
    logic [REC_W-1:0] held;
    stalled = 1'b0;
    held = '0;
    got.delete();
    for (int i = 0; i < ncyc; i++) begin
      if (stalled) begin
        chk("stall_vld", 128'(rd_vld), 128'(1));
        chk("stall_dat", 128'(rd_data), 128'(held));
      end
      rd_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = rd_vld && !rd_rdy;
      held = rd_data;
      if (rd_vld && rd_rdy) got.push_back(trace_rec_t'(rd_data));
      tick();
    end
    rd_rdy = 1'b0;
    chk("drain_end_vld", 128'(rd_vld), 128'(0));
  endtask

  task automatic chk_seq(input string tag, input logic [15:0] first, input int n);
    chk({tag, "_n"}, 128'(got.size()), 128'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk({tag, "_p"}, 128'(got[i].p), 128'(first + 16'(i)));
  endtask

  initial begin
    // 1: reset and IDLE behaviour
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk("rst_state", 128'(state_o), 128'(0));
    chk("rst_cnt", 128'(cnt), 128'(0));
    chk("rst_wrap", 128'(wrapped), 128'(0));
    chk("rst_vld", 128'(rd_vld), 128'(0));
    smp(16'h0001); smp(16'h0002);
    chk("idle_cnt", 128'(cnt), 128'(0));

    // 2: basic capture and ordered readout
    pulse_arm();
    chk("arm_state", 128'(state_o), 128'(1));
    for (int i = 0; i < 5; i++) smp(16'h0100 + 16'(i));
    pulse_stop();
    chk("t2_state", 128'(state_o), 128'(3));
    chk("t2_cnt", 128'(cnt), 128'(5));
    chk("t2_wrap", 128'(wrapped), 128'(0));
    drain(12, 1'b0);
    chk_seq("t2", 16'h0100, 5);
    if (got.size() > 0) begin
      chk("t2_a", 128'(got[0].a), 128'(16'hFEFF));
      chk("t2_t", 128'(got[0].t), 128'(32'hA5A5_0100));
    end
    chk("t2_cnt_hold", 128'(cnt), 128'(5));

    // 3: wrap-around keeps the newest DEPTH records
    pulse_arm();
    for (int i = 0; i < 12; i++) smp(16'(i));
    pulse_stop();
    chk("t3_cnt", 128'(cnt), 128'(8));
    chk("t3_wrap", 128'(wrapped), 128'(1));
    drain(14, 1'b0);
    chk_seq("t3", 16'h0004, 8);

    // 4: PC trigger with three post-trigger records
    trig_en = 1'b1; trig_pc = 16'h0020;
    pulse_arm();
    for (int i = 0; i < 24; i++) begin
      smp(16'h0010 + 16'(i));
      if (i == 18) chk("t4_post", 128'(state_o), 128'(2));
      if (i == 19) chk("t4_done", 128'(state_o), 128'(3));
    end
    chk("t4_cnt", 128'(cnt), 128'(8));
    drain(14, 1'b0);
    chk_seq("t4", 16'h001C, 8);
    trig_en = 1'b0;

    // 5: CALL-mode filter
    mode = 2'd1;
    pulse_arm();
    smp(16'h0030, 8'hB6, 3'd0, 8'd1);
    smp(16'h0031, 8'hB6, 3'd1, 8'd1);
    smp(16'h0040, 8'hB6, 3'd2, 8'd3);
    smp(16'h0032, 8'h60, 3'd2, 8'd3);
    smp(16'h0041, 8'hB1, 3'd0, 8'd2);
    smp(16'h0033, 8'hB1, 3'd1, 8'd2);
    smp(16'h0034, 8'hB1, 3'd2, 8'd2);
    smp(16'h0035, 8'h60, 3'd0, 8'd2);
    smp(16'h0050, 8'hB6, 3'd2, 8'd4);
    smp(16'h0051, 8'hB1, 3'd0, 8'd3);
    pulse_stop();
    chk("t5_cnt", 128'(cnt), 128'(4));
    drain(12, 1'b0);
    chk("t5_n", 128'(got.size()), 128'(4));
    if (got.size() == 4) begin
      chk("t5_op0", 128'(got[0].op), 128'(8'hB6));
      chk("t5_p0", 128'(got[0].p), 128'(16'h0040));
      chk("t5_rp0", 128'(got[0].rp), 128'(3));
      chk("t5_op1", 128'(got[1].op), 128'(8'hB1));
      chk("t5_ph1", 128'(got[1].ph), 128'(0));
      chk("t5_rp1", 128'(got[1].rp), 128'(2));
      chk("t5_p2", 128'(got[2].p), 128'(16'h0050));
      chk("t5_p3", 128'(got[3].p), 128'(16'h0051));
      chk("t5_rp3", 128'(got[3].rp), 128'(3));
    end

    // RANGE mode, including an empty window
    mode = 2'd2; lo = 16'h0030; hi = 16'h0032;
    pulse_arm();
    for (int i = 0; i < 5; i++) smp(16'h002F + 16'(i));
    chk("rng_cnt", 128'(cnt), 128'(3));
    lo = 16'h0040; hi = 16'h003F;
    pulse_arm();
    for (int i = 0; i < 3; i++) smp(16'h003F + 16'(i));
    chk("rng_empty_cnt", 128'(cnt), 128'(0));
    pulse_stop();
    drain(4, 1'b0);
    chk("rng_empty_n", 128'(got.size()), 128'(0));
    mode = 2'd0;

    // 6: random back-pressure, then arm mid-readout, then reset during POST
    pulse_arm();
    for (int i = 0; i < 6; i++) smp(16'h0200 + 16'(i));
    pulse_stop();
    drain(60, 1'b1);
    chk_seq("t6", 16'h0200, 6);

    pulse_arm();
    for (int i = 0; i < 5; i++) smp(16'h0300 + 16'(i));
    pulse_stop();
    rd_rdy = 1'b1;
    tick(); tick();
    chk("mid_vld_pre", 128'(rd_vld), 128'(1));
    pulse_arm();
    rd_rdy = 1'b0;
    chk("mid_vld", 128'(rd_vld), 128'(0));
    chk("mid_cnt", 128'(cnt), 128'(0));
    chk("mid_state", 128'(state_o), 128'(1));

    trig_en = 1'b1; trig_pc = 16'h0400;
    smp(16'h03FF); smp(16'h0400); smp(16'h0401);
    chk("rp_post", 128'(state_o), 128'(2));
    #2 rst = 1'b0;
    #1;
    chk("rp_state", 128'(state_o), 128'(0));
    chk("rp_cnt", 128'(cnt), 128'(0));
    chk("rp_wrap", 128'(wrapped), 128'(0));
    chk("rp_vld", 128'(rd_vld), 128'(0));
    chk("rp_data", 128'(rd_data), 128'(0));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
